// File: rtl/meu_arbitro8way16.sv
// Round-robin arbiter for eight 16-bit sources sharing one destination.
// Each grant is capped at QUANTUM beats, and the next grant is made on the release edge.
module meu_arbitro8way16 #(
    parameter int QUANTUM = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   req,
    input  logic [127:0] dados_in,
    input  logic         pronto_destino,
    output logic [15:0]  saida_dados,
    output logic         saida_valida,
    output logic [2:0]   seletor_ctrl,
    output logic [7:0]   concessao,
    output logic [7:0]   ack,
    output logic         ocupado,
    output logic         estado_dbg,
    output logic [2:0]   ptr_dbg
);

    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    localparam logic [3:0] ULTIMO = 4'(QUANTUM - 1);

    estado_t    estado, estado_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] sel, sel_n;
    logic [3:0] cnt, cnt_n;
    logic       valido, transf;
    logic [3:0] arb_ocioso, arb_lib;

    // Returns {found, index} of the first requester at or after p (mod 8).
    function automatic logic [3:0] arbitrar(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // saida_valida/pronto_destino: a beat moves in a cycle where both are high;
    // saida_valida never depends on pronto_destino, and ack marks exactly those cycles.
    always_comb begin
        valido       = (estado == CONCEDIDO) && req[sel] && !reset;
        transf       = valido && pronto_destino;
        saida_valida = valido;
        saida_dados  = valido ? dados_in[{sel, 4'b0000} +: 16] : 16'h0000;
        ack          = transf ? (8'h01 << sel) : 8'h00;
    end

    always_comb begin
        estado_n   = estado;
        ptr_n      = ptr;
        sel_n      = sel;
        cnt_n      = cnt;
        arb_ocioso = arbitrar(req, ptr);
        arb_lib    = arbitrar(req, sel + 3'd1);
        case (estado)
            OCIOSO: begin
                if (arb_ocioso[3]) begin
                    estado_n = CONCEDIDO;
                    sel_n    = arb_ocioso[2:0];
                    cnt_n    = 4'd0;
                end
            end
            CONCEDIDO: begin
                // Release on withdrawal or on the final beat of the quantum.
                if (!req[sel] || (transf && cnt == ULTIMO)) begin
                    ptr_n = sel + 3'd1;
                    cnt_n = 4'd0;
                    if (arb_lib[3]) sel_n = arb_lib[2:0];
                    else            estado_n = OCIOSO;
                end else if (transf) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= OCIOSO;
            ptr          <= 3'd0;
            sel          <= 3'd0;
            cnt          <= 4'd0;
            concessao    <= 8'h00;
            seletor_ctrl <= 3'd0;
            ocupado      <= 1'b0;
        end else begin
            estado       <= estado_n;
            ptr          <= ptr_n;
            sel          <= sel_n;
            cnt          <= cnt_n;
            concessao    <= (estado_n == CONCEDIDO) ? (8'h01 << sel_n) : 8'h00;
            seletor_ctrl <= sel_n;
            ocupado      <= (estado_n == CONCEDIDO);
        end
    end

    assign estado_dbg = estado;
    assign ptr_dbg    = ptr;

endmodule

// File: tb/tb_meu_arbitro8way16.sv
// Bench for meu_arbitro8way16: scenario tasks with a scoreboard queue of expected beats.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
module tb_meu_arbitro8way16;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] dados_in;
    logic         pronto_destino;
    logic [15:0]  saida_dados;
    logic         saida_valida;
    logic [2:0]   seletor_ctrl;
    logic [7:0]   concessao;
    logic [7:0]   ack;
    logic         ocupado;
    logic         estado_dbg;
    logic [2:0]   ptr_dbg;

    logic [15:0]  dado [8];
    logic [18:0]  exp_q [$];
    logic [18:0]  exp_w;
    logic         exp_ok;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_dados
        assign dados_in[16*g +: 16] = dado[g];
    end

    meu_arbitro8way16 #(.QUANTUM(4)) dut (
        .clk(clk), .reset(reset), .req(req), .dados_in(dados_in),
        .pronto_destino(pronto_destino), .saida_dados(saida_dados),
        .saida_valida(saida_valida), .seletor_ctrl(seletor_ctrl),
        .concessao(concessao), .ack(ack), .ocupado(ocupado),
        .estado_dbg(estado_dbg), .ptr_dbg(ptr_dbg)
    );

    function automatic logic [2:0] idx_de(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic proximo();
        @(posedge clk);
        #2;
    endtask

    task automatic pop_exp(output logic ok, output logic [18:0] w);
        ok = (exp_q.size() != 0);
        w  = ok ? exp_q.pop_front() : 19'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        proximo();
        proximo();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic novos_dados();
        for (int i = 0; i < 8; i++) dado[i] = 16'($urandom_range(0, 65535));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 8'hFF;
        pronto_destino = 1'b1;
        novos_dados();
        for (int c = 0; c < 2; c++) begin
            proximo();
            #1;
            n_checks++;
            if ({concessao, seletor_ctrl, saida_valida, saida_dados, ack, ocupado, estado_dbg, ptr_dbg} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: cycle %0d conc=%h sel=%0d val=%b dados=%h ack=%h ocup=%b, expected all zero",
                         c, concessao, seletor_ctrl, saida_valida, saida_dados, ack, ocupado);
            end
        end
        reset = 1'b0;
        proximo();
        #1;
        n_checks++;
        if (concessao !== 8'h01 || seletor_ctrl !== 3'd0 || ocupado !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: conc=%h sel=%0d ocup=%b, expected 01/0/1", concessao, seletor_ctrl, ocupado);
        end
        req = 8'h00;
        proximo();
        #1;
        n_checks++;
        if (ocupado !== 1'b0 || concessao !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle_again: ocup=%b conc=%h, expected 0/00", ocupado, concessao);
        end
    endtask

    task automatic test_single_stream();
        do_reset();
        novos_dados();
        dado[3] = 16'hA5A3;
        pronto_destino = 1'b1;
        req = 8'h08;
        #1;
        n_checks++;
        if (concessao !== 8'h00 || ack !== 8'h00) begin
            n_fail++;
            $display("FAIL stream_pregrant: conc=%h ack=%h, expected 00/00", concessao, ack);
        end
        proximo();
        for (int k = 0; k < 12; k++) exp_q.push_back({3'd3, 16'hA5A3});
        for (int c = 0; c < 12; c++) begin
            #1;
            n_checks++;
            if ({concessao, ack, saida_valida} !== {8'h08, 8'h08, 1'b1}) begin
                n_fail++;
                $display("FAIL stream_beat: cycle %0d conc=%h ack=%h val=%b, expected 08/08/1", c, concessao, ack, saida_valida);
            end
            if (ack !== 8'h00) begin
                pop_exp(exp_ok, exp_w);
                n_checks++;
                if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                    n_fail++;
                    $display("FAIL stream_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
                end
            end
            proximo();
        end
        req = 8'h00;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_missing: %0d beats never acked, expected 0", exp_q.size());
        end
        proximo();
    endtask

    task automatic test_all_sources();
        logic [2:0] s;
        do_reset();
        novos_dados();
        pronto_destino = 1'b1;
        req = 8'hFF;
        proximo();
        for (int k = 0; k < 64; k++) begin
            s = 3'((k / 4) % 8);
            exp_q.push_back({s, dado[s]});
        end
        for (int c = 0; c < 64; c++) begin
            s = 3'((c / 4) % 8);
            #1;
            n_checks++;
            if (seletor_ctrl !== s || saida_valida !== 1'b1 || ack !== (8'h01 << s)) begin
                n_fail++;
                $display("FAIL rotate_sel: cycle %0d sel=%0d val=%b ack=%h, expected sel=%0d val=1", c, seletor_ctrl, saida_valida, ack, s);
            end
            if (ack !== 8'h00) begin
                pop_exp(exp_ok, exp_w);
                n_checks++;
                if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rotate_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
                end
            end
            proximo();
        end
        req = 8'h00;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rotate_missing: %0d beats never acked, expected 0", exp_q.size());
        end
        proximo();
    endtask

    task automatic test_backpressure();
        do_reset();
        novos_dados();
        pronto_destino = 1'b1;
        req = 8'h03;
        proximo();
        for (int k = 0; k < 4; k++) exp_q.push_back({3'd0, dado[0]});
        exp_q.push_back({3'd1, dado[1]});
        for (int c = 0; c < 9; c++) begin
            pronto_destino = (c < 2 || c > 6);
            #1;
            n_checks++;
            if (concessao !== 8'h01 || saida_valida !== 1'b1 || saida_dados !== dado[0] ||
                ack !== (pronto_destino ? 8'h01 : 8'h00)) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d conc=%h val=%b dados=%h ack=%h, expected 01/1/%h ready=%b",
                         c, concessao, saida_valida, saida_dados, ack, dado[0], pronto_destino);
            end
            if (ack !== 8'h00) begin
                pop_exp(exp_ok, exp_w);
                n_checks++;
                if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                    n_fail++;
                    $display("FAIL bp_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
                end
            end
            proximo();
        end
        #1;
        n_checks++;
        if (concessao !== 8'h02 || ack !== 8'h02) begin
            n_fail++;
            $display("FAIL bp_handover: conc=%h ack=%h, expected 02/02", concessao, ack);
        end
        if (ack !== 8'h00) begin
            pop_exp(exp_ok, exp_w);
            n_checks++;
            if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                n_fail++;
                $display("FAIL bp_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
            end
        end
        req = 8'h00;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_missing: %0d beats never acked, expected 0", exp_q.size());
        end
        proximo();
    endtask

    task automatic test_withdrawal();
        do_reset();
        novos_dados();
        pronto_destino = 1'b1;
        req = 8'h20;
        proximo();
        exp_q.push_back({3'd5, dado[5]});
        exp_q.push_back({3'd5, dado[5]});
        exp_q.push_back({3'd6, dado[6]});
        req = 8'h64;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (concessao !== 8'h20 || ack !== 8'h20) begin
                n_fail++;
                $display("FAIL wd_grant5: cycle %0d conc=%h ack=%h, expected 20/20", c, concessao, ack);
            end
            if (ack !== 8'h00) begin
                pop_exp(exp_ok, exp_w);
                n_checks++;
                if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                    n_fail++;
                    $display("FAIL wd_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
                end
            end
            proximo();
        end
        req = 8'h44;
        #1;
        n_checks++;
        if (saida_valida !== 1'b0 || ack !== 8'h00 || saida_dados !== 16'h0000) begin
            n_fail++;
            $display("FAIL wd_drop: val=%b ack=%h dados=%h, expected 0/00/0000", saida_valida, ack, saida_dados);
        end
        proximo();
        #1;
        n_checks++;
        if (concessao !== 8'h40 || seletor_ctrl !== 3'd6 || ptr_dbg !== 3'd6 || ack !== 8'h40) begin
            n_fail++;
            $display("FAIL wd_next: conc=%h sel=%0d ptr=%0d ack=%h, expected 40/6/6/40", concessao, seletor_ctrl, ptr_dbg, ack);
        end
        if (ack !== 8'h00) begin
            pop_exp(exp_ok, exp_w);
            n_checks++;
            if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                n_fail++;
                $display("FAIL wd_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
            end
        end
        req = 8'h00;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wd_missing: %0d beats never acked, expected 0", exp_q.size());
        end
        proximo();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        novos_dados();
        pronto_destino = 1'b1;
        req = 8'h10;
        proximo();
        exp_q.push_back({3'd4, dado[4]});
        #1;
        n_checks++;
        if (concessao !== 8'h10 || ack !== 8'h10) begin
            n_fail++;
            $display("FAIL rm_grant4: conc=%h ack=%h, expected 10/10", concessao, ack);
        end
        if (ack !== 8'h00) begin
            pop_exp(exp_ok, exp_w);
            n_checks++;
            if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                n_fail++;
                $display("FAIL rm_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
            end
        end
        proximo();
        reset = 1'b1;
        #1;
        n_checks++;
        if (ack !== 8'h00 || saida_valida !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_no_ack: ack=%h val=%b, expected 00/0", ack, saida_valida);
        end
        proximo();
        reset = 1'b0;
        req = 8'h11;
        #1;
        n_checks++;
        if ({concessao, seletor_ctrl, saida_valida, saida_dados, ack, ocupado, estado_dbg} !== '0) begin
            n_fail++;
            $display("FAIL rm_zero: conc=%h sel=%0d val=%b dados=%h ack=%h ocup=%b, expected all zero",
                     concessao, seletor_ctrl, saida_valida, saida_dados, ack, ocupado);
        end
        proximo();
        exp_q.push_back({3'd0, dado[0]});
        #1;
        n_checks++;
        if (concessao !== 8'h01 || seletor_ctrl !== 3'd0) begin
            n_fail++;
            $display("FAIL rm_regrant: conc=%h sel=%0d, expected 01/0", concessao, seletor_ctrl);
        end
        if (ack !== 8'h00) begin
            pop_exp(exp_ok, exp_w);
            n_checks++;
            if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                n_fail++;
                $display("FAIL rm_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
            end
        end
        req = 8'h00;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rm_missing: %0d beats never acked, expected 0", exp_q.size());
        end
        proximo();
    endtask

    task automatic test_random_ready();
        int ciclos;
        do_reset();
        novos_dados();
        req = 8'hFF;
        for (int k = 0; k < 32; k++) exp_q.push_back({3'(k / 4), dado[k / 4]});
        proximo();
        ciclos = 0;
        while (exp_q.size() != 0 && ciclos < 400) begin
            pronto_destino = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (saida_valida !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_valid: cycle %0d val=%b, expected 1", ciclos, saida_valida);
            end
            if (ack !== 8'h00) begin
                pop_exp(exp_ok, exp_w);
                n_checks++;
                if (!exp_ok || {idx_de(ack), saida_dados} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rnd_sb: got src=%0d data=%h, expected %h (present=%b)", idx_de(ack), saida_dados, exp_w, exp_ok);
                end
            end
            proximo();
            ciclos++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_timeout: %0d beats left after %0d cycles, expected 0", exp_q.size(), ciclos);
        end
        req = 8'h00;
        pronto_destino = 1'b1;
        proximo();
    endtask

    initial begin
        reset = 1'b1;
        req = 8'h00;
        pronto_destino = 1'b0;
        for (int i = 0; i < 8; i++) dado[i] = 16'h0000;
        test_reset();
        test_single_stream();
        test_all_sources();
        test_backpressure();
        test_withdrawal();
        test_reset_mid_grant();
        test_random_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/meu_arbitro8way16.md
# meu_arbitro8way16

Round-robin arbiter and sequencer for the shared 16-bit, 8-input data path. It accepts requests from eight 16-bit sources and grants the bus to one source at a time. It drives the 3-bit selector of the 8-way mux and forwards the selected word to a single destination using a valid/ready handshake. Each grant is limited to a fixed beat quantum so that no source can starve the others.

## Interface
- `QUANTUM`, default 4: maximum beats per grant; legal range 1..15.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  8  per-source request; bit i high means source i has a word on its data slice.
- `dados_in`  input  128  source data, flattened; source i occupies bits [16i+15:16i].
- `pronto_destino`  input  1  destination ready.
- `saida_dados`  output  16  selected word; forced to 16'h0000 while `saida_valida` is low.
- `saida_valida`  output  1  a word is offered to the destination.
- `seletor_ctrl`  output  3  index of the granted source (the mux select).
- `concessao`  output  8  one-hot grant; all zeros when idle.
- `ack`  output  8  one-hot beat-accepted pulse, returned to the granted source.
- `ocupado`  output  1  high while in state CONCEDIDO.

## Operation
- **States:**
  - OCIOSO: no grant held.
  - CONCEDIDO: one source owns the bus.
- **Registered state:**
  - `ptr` (3 bits): the highest-priority index.
  - `sel` (3 bits): the granted index.
  - `cnt` (4 bits): beats in the current grant.
- **Arbitration:** the winner is the first i with `req[i]` high, scanning `ptr`, `ptr+1`, … `ptr+7` (mod 8).
- **OCIOSO:**
  - If any `req` bit is high, the next edge sets `sel` to the winner, clears `cnt` and enters CONCEDIDO.
  - Otherwise stay in OCIOSO.
- **CONCEDIDO:**
  - `saida_valida` = `req[sel]`.
  - `saida_dados` = `dados_in` slice `sel`, routed through the mux.
  - A beat transfers when `saida_valida` and `pronto_destino` are both high in the same cycle. In that cycle `ack[sel]` = 1 and `cnt` increments at the edge.
- **Release conditions (evaluated every cycle in CONCEDIDO):**
  - (a) `req[sel]` is low. The source withdrew; no beat is lost because no ack was issued.
  - (b) A beat transfers while `cnt == QUANTUM-1`.
- **On release, at the same edge:**
  - `ptr` ← `sel+1`.
  - Arbitration is re-run on the current `req` using the new `ptr`.
  - If there is a winner, grant it directly with `cnt` cleared. There is no idle bubble.
  - If there is no winner, go to OCIOSO.
  - The releasing source has lowest priority in this re-arbitration. After a quantum expiry it is re-granted only if no other source requests.
- **Source contract:**
  - Hold `req` and the data slice stable until `ack`.
  - Dropping `req` before `ack` aborts that word.
  - `req` may stay high across beats to stream.
- **Backpressure:** while `pronto_destino` is low, grant, `saida_dados`, `cnt` and `ptr` all hold. There is no timeout.
- **Width rules:**
  - All index arithmetic is mod 8; `ptr` wraps from 7 to 0.
  - `cnt` never exceeds `QUANTUM-1`.

## Timing
- **Reset** (synchronous, checked at every edge; overrides everything including a mid-grant transfer):
  - State OCIOSO; `ptr` = 0, `sel` = 0, `cnt` = 0.
  - `concessao` = 8'h00, `seletor_ctrl` = 3'd0, `saida_valida` = 0, `saida_dados` = 16'h0000, `ack` = 8'h00, `ocupado` = 0.
  - No ack is issued in the reset cycle.
- **Grant latency:** one edge from `req` being sampled high in OCIOSO to `concessao` and `seletor_ctrl` valid.
- **Output timing:**
  - `concessao`, `seletor_ctrl` and `ocupado` are registered.
  - `saida_valida`, `saida_dados` and `ack` are combinational from the registered `sel`, `req`, `dados_in` and `pronto_destino`.
- **Handover:** zero-cycle gap. The last beat of one grant and the first beat of the next occur in consecutive cycles.
- **Throughput:** one word per cycle while `pronto_destino` = 1 and requests are continuous.
- **Fairness bound:** a continuously requesting source is granted within 7×`QUANTUM` beats, plus any backpressure cycles.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `req` = 8'hFF, then release → during reset all outputs are zero. After the first edge out of reset, `concessao` = 8'h01 and `seletor_ctrl` = 0.
- **Single source streaming:** `req` = 8'h08, source 3 data = 16'hA5A3, `pronto_destino` = 1, `QUANTUM` = 4 → grant 8'h08 one edge later; `ack[3]` every cycle; `saida_dados` = 16'hA5A3. The quantum expiry every 4 beats re-grants source 3 with no gap.
- **All sources requesting:** `req` = 8'hFF, `pronto_destino` = 1 → `seletor_ctrl` steps 0,1,…,7,0, holding each value for exactly 4 cycles; 32 acks per rotation; no cycle with `saida_valida` low.
- **Backpressure:** drop `pronto_destino` for 5 cycles after beat 2 of source 0 → `saida_valida` stays high, data stable, `ack` = 0, grant held. Beats 3 and 4 complete after ready returns, then handover to the next requester.
- **Withdrawal:** source 5 is granted, and `req[2]` and `req[6]` are also high. Source 5 drops `req` after 2 acks → the next edge grants source 6, not source 2, and `ptr` = 6.
- **Reset mid-grant:** assert `reset` during an accepted beat of source 4 → no `ack[4]` in that cycle. Next cycle all outputs are zero. After release with `req` = 8'h11, source 0 is granted first.
